// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// ----------------
// Shares one memory port between an instruction-fetch requester (if_*) and a
// data memory-access requester (ma_*). Data normally wins, but after
// STARVE_LIMIT consecutive data grants while fetch is waiting, fetch is
// granted once. A transaction is IDLE (arbitrate) -> BUSY (drive memory
// until mem_ack) -> RESP (one-cycle done pulse) -> IDLE.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   if_req/if_addr       fetch read request (held until if_done)
//   if_rdata/if_done     fetch read data (held) and completion pulse
//   if_stall             if_req & ~if_done
//   ma_req/we/be/addr/wdata  data request (held until ma_done)
//   ma_rdata/ma_done     data read result (held) and completion pulse
//   ma_stall             ma_req & ~ma_done
//   mem_req/we/be/addr/wdata  shared memory port, stable while mem_req=1
//   mem_ack/mem_rdata    memory completion, read data valid with ack
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_done,
  output logic        if_stall,
  input  logic        ma_req,
  input  logic        ma_we,
  input  logic [3:0]  ma_be,
  input  logic [31:0] ma_addr,
  input  logic [31:0] ma_wdata,
  output logic [31:0] ma_rdata,
  output logic        ma_done,
  output logic        ma_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]    state_reg;
  logic [CW-1:0] starve_cnt_reg;
  logic          owner_data_reg;   // 1: current transaction belongs to ma_*
  logic          mem_we_reg;
  logic [3:0]    mem_be_reg;
  logic [31:0]   mem_addr_reg;
  logic [31:0]   mem_wdata_reg;
  logic [31:0]   if_rdata_reg;
  logic [31:0]   ma_rdata_reg;

  logic grant_data;
  logic grant_fetch;

  // Arbitration happens only in IDLE; fetch overrides data once the
  // starvation counter has reached its limit while fetch is waiting.
  always_comb begin
    grant_data  = 1'b0;
    grant_fetch = 1'b0;
    if (state_reg == IDLE) begin
      if (ma_req && !(if_req && (starve_cnt_reg == LIMIT))) begin
        grant_data = 1'b1;
      end else if (if_req) begin
        grant_fetch = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      starve_cnt_reg <= '0;
      owner_data_reg <= 1'b0;
      mem_we_reg     <= 1'b0;
      mem_be_reg     <= 4'h0;
      mem_addr_reg   <= 32'h0;
      mem_wdata_reg  <= 32'h0;
      if_rdata_reg   <= 32'h0;
      ma_rdata_reg   <= 32'h0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_data) begin
            state_reg      <= BUSY;
            owner_data_reg <= 1'b1;
            mem_we_reg     <= ma_we;
            mem_be_reg     <= ma_be;
            mem_addr_reg   <= ma_addr;
            mem_wdata_reg  <= ma_wdata;
            // Count only grants that made fetch wait; saturate at the limit.
            if (!if_req) begin
              starve_cnt_reg <= '0;
            end else if (starve_cnt_reg != LIMIT) begin
              starve_cnt_reg <= starve_cnt_reg + 1'b1;
            end
          end else if (grant_fetch) begin
            state_reg      <= BUSY;
            owner_data_reg <= 1'b0;
            mem_we_reg     <= 1'b0;
            mem_be_reg     <= 4'hF;
            mem_addr_reg   <= if_addr;
            mem_wdata_reg  <= 32'h0;
            starve_cnt_reg <= '0;
          end
        end
        BUSY: begin
          if (mem_ack) begin
            state_reg <= RESP;
            // Read data is captured here so it is valid in the done cycle.
            if (!mem_we_reg) begin
              if (owner_data_reg) begin
                ma_rdata_reg <= mem_rdata;
              end else begin
                if_rdata_reg <= mem_rdata;
              end
            end
          end
        end
        RESP: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign mem_req   = (state_reg == BUSY);
  assign mem_we    = mem_we_reg;
  assign mem_be    = mem_be_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;

  assign if_done   = (state_reg == RESP) && !owner_data_reg;
  assign ma_done   = (state_reg == RESP) &&  owner_data_reg;
  assign if_rdata  = if_rdata_reg;
  assign ma_rdata  = ma_rdata_reg;

  assign if_stall  = if_req & ~if_done;
  assign ma_stall  = ma_req & ~ma_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios plus randomized traffic,
// all checked cycle by cycle against a transaction-level reference model and
// a word-addressed memory model.
module tb_mem_port_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        if_stall;
  logic        ma_req;
  logic        ma_we;
  logic [3:0]  ma_be;
  logic [31:0] ma_addr;
  logic [31:0] ma_wdata;
  logic [31:0] ma_rdata;
  logic        ma_done;
  logic        ma_stall;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_done(if_done), .if_stall(if_stall),
    .ma_req(ma_req), .ma_we(ma_we), .ma_be(ma_be), .ma_addr(ma_addr),
    .ma_wdata(ma_wdata), .ma_rdata(ma_rdata), .ma_done(ma_done),
    .ma_stall(ma_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- memory model ----------------
  logic [31:0] mem_arr [logic [31:0]];

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem_arr.exists(a)) return mem_arr[a];
    return a ^ 32'h5A5A_0F0F;
  endfunction

  // ---------------- reference model ----------------
  bit          m_busy = 0;
  bit          m_resp = 0;
  bit          m_owner_data = 0;
  bit          m_we = 0;
  logic [3:0]  m_be = 4'h0;
  logic [31:0] m_addr = 32'h0;
  logic [31:0] m_wdata = 32'h0;
  logic [31:0] m_if_rdata = 32'h0;
  logic [31:0] m_ma_rdata = 32'h0;
  int          m_starve = 0;

  // ---------------- observation ----------------
  int          cyc = 0;
  bit          seen_if_done = 0;
  bit          seen_ma_done = 0;
  bit          prev_mem_req = 0;
  int          obs_memreq_cnt;
  int          obs_if_done_cyc;
  int          obs_ma_done_cyc;
  int          obs_if_stall_cnt;
  int          grant_cyc[$];
  logic [31:0] grant_addr[$];
  bit          grant_we[$];

  // ---------------- stimulus control ----------------
  bit rand_mode = 0;
  bit spurious_en = 0;
  int ack_delay = 0;
  int ack_override = -1;
  int mem_busy_cnt = 0;

  task automatic clear_obs();
    obs_memreq_cnt   = 0;
    obs_if_done_cyc  = -1;
    obs_ma_done_cyc  = -1;
    obs_if_stall_cnt = 0;
    grant_cyc.delete();
    grant_addr.delete();
    grant_we.delete();
  endtask

  // Called mid-cycle: compare outputs with the model, then advance the model
  // using the inputs that the coming clock edge will sample.
  task automatic sample_and_check();
    bit          take_data;
    logic [31:0] tmp;
    bit          e_if_done;
    bit          e_ma_done;
    cyc++;
    seen_if_done = if_done;
    seen_ma_done = ma_done;
    if (mem_req) obs_memreq_cnt++;
    if (if_done) obs_if_done_cyc = cyc;
    if (ma_done) obs_ma_done_cyc = cyc;
    if (if_stall) obs_if_stall_cnt++;
    if (mem_req && !prev_mem_req) begin
      grant_cyc.push_back(cyc);
      grant_addr.push_back(mem_addr);
      grant_we.push_back(mem_we);
    end
    prev_mem_req = mem_req;

    e_if_done = m_resp && !m_owner_data;
    e_ma_done = m_resp && m_owner_data;
    check_val("mem_req", 32'(mem_req), 32'(m_busy));
    check_val("if_done", 32'(if_done), 32'(e_if_done));
    check_val("ma_done", 32'(ma_done), 32'(e_ma_done));
    check_val("if_stall", 32'(if_stall), 32'(if_req && !e_if_done));
    check_val("ma_stall", 32'(ma_stall), 32'(ma_req && !e_ma_done));
    check_val("if_rdata", if_rdata, m_if_rdata);
    check_val("ma_rdata", ma_rdata, m_ma_rdata);
    if (m_busy) begin
      check_val("mem_addr", mem_addr, m_addr);
      check_val("mem_we", 32'(mem_we), 32'(m_we));
      check_val("mem_be", 32'(mem_be), 32'(m_be));
      if (m_we) check_val("mem_wdata", mem_wdata, m_wdata);
    end

    if (rst) begin
      m_busy = 0; m_resp = 0; m_starve = 0;
      m_if_rdata = 32'h0; m_ma_rdata = 32'h0;
    end else if (m_resp) begin
      m_resp = 0;
    end else if (m_busy) begin
      if (mem_ack) begin
        m_busy = 0;
        m_resp = 1;
        tmp = mem_read(m_addr);
        if (m_we) begin
          for (int b = 0; b < 4; b++)
            if (m_be[b]) tmp[8*b +: 8] = m_wdata[8*b +: 8];
          mem_arr[m_addr] = tmp;
        end else if (m_owner_data) begin
          m_ma_rdata = tmp;
        end else begin
          m_if_rdata = tmp;
        end
      end
    end else if (ma_req || if_req) begin
      take_data = ma_req && !(if_req && m_starve == LIMIT);
      if (take_data) begin
        m_owner_data = 1; m_addr = ma_addr; m_we = ma_we;
        m_be = ma_be; m_wdata = ma_wdata;
        m_starve = if_req ? ((m_starve < LIMIT) ? m_starve + 1 : LIMIT) : 0;
      end else begin
        m_owner_data = 0; m_addr = if_addr; m_we = 0;
        m_be = 4'hF; m_wdata = 32'h0;
        m_starve = 0;
      end
      m_busy = 1;
    end
  endtask

  task automatic drive_random();
    if (!if_req || seen_if_done) begin
      if ($urandom_range(2) == 0) begin
        if_req  = 1'b1;
        if_addr = 32'h8000_0000 | 32'($urandom_range(15) << 2);
      end else begin
        if_req = 1'b0;
      end
    end else if (m_busy && m_owner_data) begin
      if_addr = $urandom;   // waiting requester wiggles its inputs
    end
    if (!ma_req || seen_ma_done) begin
      if ($urandom_range(1) == 0) begin
        ma_req   = 1'b1;
        ma_we    = 1'($urandom_range(1));
        ma_be    = 4'($urandom);
        ma_addr  = 32'h8000_0000 | 32'($urandom_range(15) << 2);
        ma_wdata = $urandom;
      end else begin
        ma_req = 1'b0;
      end
    end else if (m_busy && !m_owner_data) begin
      ma_we    = 1'($urandom_range(1));
      ma_be    = 4'($urandom);
      ma_addr  = $urandom;
      ma_wdata = $urandom;
    end
  endtask

  task automatic mem_respond();
    if (ack_override >= 0) begin
      mem_ack = ack_override[0];
    end else if (mem_req) begin
      if (rand_mode && mem_busy_cnt == 0) ack_delay = $urandom_range(3);
      mem_ack = (mem_busy_cnt >= ack_delay);
      mem_busy_cnt++;
    end else begin
      mem_busy_cnt = 0;
      mem_ack = spurious_en && ($urandom_range(3) == 0);
    end
    mem_rdata = mem_req ? mem_read(mem_addr) : $urandom;
  endtask

  task automatic step();
    @(negedge clk);
    sample_and_check();
    @(posedge clk);
    #1;
    if (rand_mode) drive_random();
    mem_respond();
  endtask

  task automatic do_txn(input bit is_data, input logic [31:0] addr,
                        input bit we, input logic [3:0] be,
                        input logic [31:0] wd, input int dly,
                        output int t0);
    bit done_flag;
    ack_delay = dly;
    clear_obs();
    if (is_data) begin
      ma_req = 1'b1; ma_addr = addr; ma_we = we; ma_be = be; ma_wdata = wd;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    t0 = cyc + 1;
    done_flag = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (seen_if_done || seen_ma_done) begin
        done_flag = 1;
        break;
      end
    end
    check_val("txn_done_seen", 32'(done_flag), 32'd1);
    ma_req = 1'b0;
    if_req = 1'b0;
    $display("txn %s addr=0x%08h we=%0d dly=%0d start=%0d", is_data ? "data" : "fetch",
             addr, we, dly, t0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    bit exp_seq[10];
    bit done_flag;

    rst = 1'b1;
    if_req = 0; if_addr = 0;
    ma_req = 0; ma_we = 0; ma_be = 0; ma_addr = 0; ma_wdata = 0;
    mem_ack = 0; mem_rdata = 0;
    clear_obs();
    @(posedge clk);
    #1;
    step();
    step();
    rst = 1'b0;
    check_val("rst_mem_req", 32'(mem_req), 32'd0);
    check_val("rst_mem_we", 32'(mem_we), 32'd0);
    check_val("rst_mem_be", 32'(mem_be), 32'd0);
    check_val("rst_mem_addr", mem_addr, 32'd0);
    check_val("rst_mem_wdata", mem_wdata, 32'd0);
    check_val("rst_if_rdata", if_rdata, 32'd0);
    check_val("rst_ma_rdata", ma_rdata, 32'd0);

    // Single fetch, immediate ack.
    mem_arr[32'h100] = 32'h0000_0013;
    do_txn(0, 32'h100, 0, 4'h0, 32'h0, 0, t0);
    check_val("f_memreq_cycles", 32'(obs_memreq_cnt), 32'd1);
    check_val("f_grant_cyc", 32'(grant_cyc[0]), 32'(t0 + 1));
    check_val("f_mem_addr", grant_addr[0], 32'h100);
    check_val("f_mem_we", 32'(grant_we[0]), 32'd0);
    check_val("f_done_cyc", 32'(obs_if_done_cyc), 32'(t0 + 2));
    check_val("f_if_rdata", if_rdata, 32'h13);
    check_val("f_stall_cycles", 32'(obs_if_stall_cnt), 32'd2);

    // Data read, then a byte-enabled write with three wait cycles.
    mem_arr[32'h2000] = 32'h1122_3344;
    do_txn(1, 32'h2000, 0, 4'hF, 32'h0, 0, t0);
    check_val("d_read_rdata", ma_rdata, 32'h1122_3344);
    do_txn(1, 32'h2000, 1, 4'b0011, 32'hDEAD_BEEF, 3, t0);
    check_val("w_memreq_cycles", 32'(obs_memreq_cnt), 32'd4);
    check_val("w_mem_addr", grant_addr[0], 32'h2000);
    check_val("w_done_cyc", 32'(obs_ma_done_cyc), 32'(t0 + 5));
    check_val("w_rdata_kept", ma_rdata, 32'h1122_3344);
    do_txn(1, 32'h2000, 0, 4'hF, 32'h0, 1, t0);
    check_val("w_readback", ma_rdata, 32'h1122_BEEF);

    // Simultaneous requests: data first, fetch right after.
    clear_obs();
    ack_delay = 0;
    if_req = 1; if_addr = 32'h300;
    ma_req = 1; ma_addr = 32'h2004; ma_we = 0; ma_be = 4'hF;
    done_flag = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (seen_ma_done) ma_req = 1'b0;
      if (seen_if_done) begin
        done_flag = 1;
        break;
      end
    end
    if_req = 0;
    check_val("sim_fetch_done", 32'(done_flag), 32'd1);
    check_val("sim_first_addr", grant_addr[0], 32'h2004);
    check_val("sim_second_addr", grant_addr[1], 32'h300);
    check_val("sim_fetch_grant_cyc", 32'(grant_cyc[1]), 32'(obs_ma_done_cyc + 2));
    check_val("sim_order", 32'(obs_if_done_cyc > obs_ma_done_cyc), 32'd1);
    $display("txn simultaneous ma_done=%0d if_done=%0d", obs_ma_done_cyc, obs_if_done_cyc);

    // Starvation: fetch held, data re-requested every transaction.
    clear_obs();
    if_req = 1; if_addr = 32'h400;
    ma_req = 1; ma_addr = 32'h8000_0100; ma_we = 0; ma_be = 4'hF;
    for (int i = 0; i < 200; i++) begin
      step();
      if (grant_cyc.size() >= 10 && (seen_if_done || seen_ma_done)) break;
    end
    if_req = 0; ma_req = 0;
    exp_seq = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    for (int i = 0; i < 10; i++)
      check_val($sformatf("starve_grant%0d", i), 32'(grant_addr[i][31]),
                32'(exp_seq[i]));
    $display("txn starvation grants=%0d", grant_cyc.size());

    // Granted requester drops its request mid-transaction.
    clear_obs();
    ack_delay = 2;
    ma_req = 1; ma_addr = 32'h2008; ma_we = 0; ma_be = 4'hF;
    done_flag = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (mem_req) ma_req = 1'b0;
      if (seen_ma_done) begin
        done_flag = 1;
        break;
      end
    end
    ma_req = 0;
    check_val("drop_done", 32'(done_flag), 32'd1);
    check_val("drop_rdata", ma_rdata, mem_read(32'h2008));
    $display("txn dropped-req read done=%0d", done_flag);

    // Reset while BUSY, then a late ack.
    clear_obs();
    ack_override = 0;
    ma_req = 1; ma_addr = 32'h200C; ma_we = 0; ma_be = 4'hF;
    for (int i = 0; i < 10; i++) begin
      step();
      if (mem_req) break;
    end
    check_val("rb_memreq_before", 32'(mem_req), 32'd1);
    rst = 1; ma_req = 0;
    step();
    rst = 0;
    check_val("rb_memreq_after", 32'(mem_req), 32'd0);
    ack_override = 1;
    step();
    step();
    ack_override = -1;
    step();
    check_val("rb_no_done", 32'(obs_ma_done_cyc), 32'hFFFF_FFFF);
    check_val("rb_ma_rdata", ma_rdata, 32'd0);
    do_txn(0, 32'h104, 0, 4'h0, 32'h0, 0, t0);
    check_val("rb_idle_latency", 32'(obs_if_done_cyc), 32'(t0 + 2));
    $display("txn reset-in-busy done_cyc=%0d", obs_ma_done_cyc);

    // Spurious ack in IDLE.
    clear_obs();
    ack_override = 1;
    repeat (3) step();
    ack_override = -1;
    step();
    check_val("sp_no_if_done", 32'(obs_if_done_cyc), 32'hFFFF_FFFF);
    check_val("sp_no_ma_done", 32'(obs_ma_done_cyc), 32'hFFFF_FFFF);
    check_val("sp_if_rdata", if_rdata, mem_read(32'h104));
    check_val("sp_ma_rdata", ma_rdata, 32'd0);
    $display("txn spurious ack");

    // Randomized traffic with spurious acks.
    clear_obs();
    rand_mode = 1;
    spurious_en = 1;
    for (int i = 0; i < 3000; i++) begin
      step();
      if (seen_if_done) $display("txn rand fetch done cyc=%0d rdata=0x%08h", cyc, if_rdata);
      if (seen_ma_done) $display("txn rand data done cyc=%0d rdata=0x%08h", cyc, ma_rdata);
    end
    rand_mode = 0;
    spurious_en = 0;
    check_val("rand_activity", 32'(grant_cyc.size() > 20), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have one clock, clk, and one reset, rst, which is synchronous and active-high.
REQ-002 The block SHALL have parameter STARVE_LIMIT, default 4, giving the maximum consecutive data grants while fetch waits.
REQ-003 The block SHALL have the following ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- if_req  in  1  fetch read request; held until if_done
- if_addr  in  32  fetch address
- if_rdata  out  32  fetch read data
- if_done  out  1  fetch completion pulse
- if_stall  out  1  fetch stall
- ma_req  in  1  memory-access request; held until ma_done
- ma_we  in  1  write enable
- ma_be  in  4  byte enables
- ma_addr  in  32  data address
- ma_wdata  in  32  write data
- ma_rdata  out  32  data read result
- ma_done  out  1  data completion pulse
- ma_stall  out  1  data stall
- mem_req  out  1  shared memory port request
- mem_we  out  1  memory write enable
- mem_be  out  4  memory byte enables
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_ack  in  1  memory completion; mem_rdata is valid in the same cycle
- mem_rdata  in  32  memory read data

Function
REQ-004 The block SHALL implement FSM states IDLE, BUSY and RESP, plus a starvation counter starve_cnt.
REQ-005 IDLE SHALL arbitrate each cycle, as follows:
- only ma_req high: grant data.
- only if_req high: grant fetch.
- both high: grant data unless starve_cnt == STARVE_LIMIT, in which case grant fetch.
- neither high: stay in IDLE.
REQ-006 On a grant, the block SHALL register mem_addr, mem_we, mem_be and mem_wdata from the granted requester and enter BUSY.
- Fetch grants drive mem_we=0 and mem_be=4'hF.
- mem_req SHALL be 1 for exactly the BUSY cycles.
REQ-007 In BUSY, mem_* outputs SHALL stay stable until mem_ack=1; in the ack cycle the block SHALL go to RESP.
REQ-008 In RESP (one cycle), the block SHALL pulse the granted requester's done signal and then return to IDLE.
- RESP SHALL NOT arbitrate.
- The requester drops or replaces its req in the cycle after done.
REQ-009 On a read ack, the block SHALL capture mem_rdata into if_rdata or ma_rdata, valid from the done cycle.
- The value SHALL be held until that requester's next read completes.
- A write SHALL leave ma_rdata unchanged.
REQ-010 Minimum latency SHALL be 3 cycles:
- req sampled in IDLE at cycle N;
- mem_req=1 at N+1;
- mem_ack at N+1;
- done at N+2.
- Each additional ack wait cycle adds 1.
REQ-011 Stall outputs SHALL be combinational: if_stall = if_req & ~if_done, and ma_stall = ma_req & ~ma_done.
REQ-012 starve_cnt SHALL update only on IDLE grants:
- data grant with if_req=1: increment, saturating at STARVE_LIMIT.
- fetch grant: clear to 0.
- data grant with if_req=0: clear to 0.
REQ-013 mem_ack SHALL be ignored in IDLE and RESP.
REQ-014 If the granted requester drops req while in BUSY, the block SHALL still complete the transaction and pulse done.
REQ-015 Changes on the non-granted requester's inputs SHALL NOT affect mem_* outputs during BUSY.

Reset
REQ-016 With rst=1 at a clock edge, the next-cycle state SHALL be IDLE, starve_cnt=0, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, if_done=0, ma_done=0, if_rdata=0 and ma_rdata=0.
REQ-017 Reset during BUSY SHALL abandon the transaction: no done pulse is issued, and an ack arriving after reset is ignored.

Verification
REQ-018 The bench SHALL cover a single fetch:
- Stimulus: if_req=1, if_addr=0x100, ack on the first BUSY cycle with rdata=0x00000013.
- Response: mem_req=1 for 1 cycle with mem_addr=0x100 and mem_we=0; if_done at +2 with if_rdata=0x13; if_stall high for exactly 2 cycles.
REQ-019 The bench SHALL cover a data write:
- Stimulus: ma_req=1, ma_we=1, ma_be=4'b0011, ma_addr=0x2000, ma_wdata=0xDEADBEEF, ack after 3 wait cycles.
- Response: mem_* stable for 4 BUSY cycles; ma_done at +5; ma_rdata unchanged.
REQ-020 The bench SHALL cover a simultaneous request:
- Stimulus: if_req=1 and ma_req=1 in the same cycle.
- Response: the data request completes first; the fetch is granted in the IDLE cycle after ma_done.
REQ-021 The bench SHALL cover starvation:
- Stimulus: if_req held with STARVE_LIMIT=4 and ma_req re-asserted every transaction.
- Response: exactly 4 data grants, then a fetch grant, then starve_cnt=0.
REQ-022 The bench SHALL cover reset in BUSY:
- Stimulus: rst=1 for 1 cycle while mem_req=1, then ack=1.
- Response: mem_req=0 after the edge; no done pulse; state IDLE.
REQ-023 The bench SHALL cover a spurious ack:
- Stimulus: mem_ack=1 while in IDLE.
- Response: no done pulse and no rdata change.
